// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared state encoding and width helpers for the uart tx arbiter
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 1024;

    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester and uart-side signals of the tx arbiter
interface uart_tx_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [8*N-1:0] data;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           txreq;
    logic           txack;
    logic [7:0]     txdata;

    // master: requesters plus uart; slave: the arbiter itself
    modport master (
        output req, last, data, txack,
        input  ack, grant, txreq, txdata
    );

    modport slave (
        input  req, last, data, txack,
        output ack, grant, txreq, txdata
    );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - combinational round-robin selector, scans from ptr+1 with wrap
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-based round-robin sharing of one uart transmit channel
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    uart_tx_arb_if.slave bus
);

    localparam int            IW       = idx_width(N);
    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ack_q, ack_d;
    logic          txreq_q, txreq_d;
    logic [7:0]    txdata_q, txdata_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  win_onehot;
    logic [IW-1:0] win_idx;
    logic          win_valid;
    logic [IW-1:0] sel_idx;
    logic [7:0]    data_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_data
        assign data_arr[i] = bus.data[8*i +: 8];
    end

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    // In IDLE the byte comes from the arbitration winner, otherwise from the current owner
    assign sel_idx = (state_q == ST_IDLE) ? win_idx : ptr_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        ack_d    = '0;
        txreq_d  = txreq_q;
        txdata_d = txdata_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d  = win_onehot;
                    ptr_d    = win_idx;
                    txdata_d = data_arr[sel_idx];
                    last_d   = bus.last[sel_idx];
                    txreq_d  = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.txack) begin
                    txreq_d = 1'b0;
                    ack_d   = grant_q;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (last_q) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Only the owner is looked at here; everyone else waits for IDLE
                if (bus.req[ptr_q]) begin
                    txdata_d = data_arr[sel_idx];
                    last_d   = bus.last[sel_idx];
                    txreq_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            ack_q    <= '0;
            txreq_q  <= 1'b0;
            txdata_q <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            txreq_q  <= txreq_d;
            txdata_q <= txdata_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.grant  = grant_q;
    assign bus.txreq  = txreq_q;
    assign bus.txdata = txdata_q;

endmodule
